// File: rtl/laser_targeting.sv
// laser_targeting: once-per-frame tower scan, single-hit laser with frame cooldown, per-car health.
// Optional LASER_NEAREST_EN: choose the eligible car with the smallest dx+dy instead of the lowest index.
module laser_targeting #(
    parameter int RANGE           = 20,
    parameter int HITS_TO_KILL    = 3,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stage_in_progress,
    input  logic        frame_tick,
    input  logic [14:0] tower_coord,
    input  logic [14:0] car_0_coords,
    input  logic [14:0] car_1_coords,
    input  logic [14:0] car_2_coords,
    input  logic [14:0] car_3_coords,
    output logic [3:0]  destroyed_cars,
    output logic        laser_fire,
    output logic [1:0]  laser_target,
    output logic [14:0] laser_end_coord
);
    localparam logic [8:0] RANGE_C    = 9'(RANGE);
    localparam logic [3:0] HEALTH_C   = 4'(HITS_TO_KILL);
    localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIRE = 2'd2
    } state_t;

    // Zero-extended 9-bit signed difference, folded to magnitude, so edges never wrap.
    function automatic logic [8:0] abs_diff9(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        abs_diff9 = d[8] ? (9'd0 - d) : d;
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  idx_r;
    logic        found_r;
    logic [1:0]  sel_idx_r;
    logic [14:0] sel_coord_r;
    logic [14:0] tower_r;
    logic [7:0]  cooldown_r;
    logic [3:0]  health_r [4];
    logic [3:0]  destroyed_r;
    logic        stage_prev_r;
    logic        laser_fire_r;
    logic [1:0]  laser_target_r;
    logic [14:0] laser_end_coord_r;
`ifdef LASER_NEAREST_EN
    logic [9:0]  best_sum_r;
    logic [9:0]  sum_s;
`endif

    logic [14:0] cur_coord_s;
    logic [8:0]  dx_s, dy_s;
    logic        eligible_s, take_s, found_next_s;
    logic        stage_rise_s, start_s, fire_go_s;
    logic [1:0]  fire_idx_s;
    logic [14:0] fire_coord_s;

    // Current scan candidate and its eligibility against the latched tower position.
    always_comb begin
        case (idx_r)
            2'd0:    cur_coord_s = car_0_coords;
            2'd1:    cur_coord_s = car_1_coords;
            2'd2:    cur_coord_s = car_2_coords;
            2'd3:    cur_coord_s = car_3_coords;
            default: cur_coord_s = 15'd0;
        endcase
        dx_s = abs_diff9(cur_coord_s[14:7], tower_r[14:7]);
        dy_s = abs_diff9({1'b0, cur_coord_s[6:0]}, {1'b0, tower_r[6:0]});
        eligible_s = (cur_coord_s != 15'd0) && !destroyed_r[idx_r] &&
                     (dx_s <= RANGE_C) && (dy_s <= RANGE_C);
`ifdef LASER_NEAREST_EN
        sum_s  = {1'b0, dx_s} + {1'b0, dy_s};
        take_s = eligible_s && (!found_r || (sum_s < best_sum_r));
`else
        take_s = eligible_s && !found_r;
`endif
        found_next_s = found_r | eligible_s;
        stage_rise_s = stage_in_progress && !stage_prev_r;
        start_s      = (state_r == IDLE) && frame_tick && (cooldown_r == 8'd0) && stage_in_progress;
        fire_go_s    = (state_r == SCAN) && (idx_r == 2'd3) && found_next_s &&
                       stage_in_progress && !stage_rise_s;
        fire_idx_s   = take_s ? idx_r : sel_idx_r;
        fire_coord_s = take_s ? cur_coord_s : sel_coord_r;
    end

    // Next-state logic; a stage edge or an inactive stage always parks the FSM in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_s = SCAN;
                else         state_s = IDLE;
            end
            SCAN: begin
                if (idx_r != 2'd3) state_s = SCAN;
                else if (fire_go_s) state_s = FIRE;
                else                state_s = IDLE;
            end
            FIRE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        if (stage_rise_s || !stage_in_progress) state_s = IDLE;
        else                                    state_s = state_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Scan bookkeeping, cooldown, health and registered laser outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_prev_r      <= 1'b0;
            idx_r             <= 2'd0;
            found_r           <= 1'b0;
            sel_idx_r         <= 2'd0;
            sel_coord_r       <= 15'd0;
            tower_r           <= 15'd0;
            cooldown_r        <= 8'd0;
            destroyed_r       <= 4'd0;
            laser_fire_r      <= 1'b0;
            laser_target_r    <= 2'd0;
            laser_end_coord_r <= 15'd0;
            for (int i = 0; i < 4; i++) health_r[i] <= HEALTH_C;
`ifdef LASER_NEAREST_EN
            best_sum_r        <= 10'h3FF;
`endif
        end else begin
            stage_prev_r <= stage_in_progress;
            laser_fire_r <= 1'b0;
            if (stage_rise_s) begin
                idx_r       <= 2'd0;
                found_r     <= 1'b0;
                cooldown_r  <= 8'd0;
                destroyed_r <= 4'd0;
                for (int i = 0; i < 4; i++) health_r[i] <= HEALTH_C;
            end else begin
                if (fire_go_s)                              cooldown_r <= COOLDOWN_C;
                else if (frame_tick && cooldown_r != 8'd0)  cooldown_r <= cooldown_r - 8'd1;
                else                                        cooldown_r <= cooldown_r;

                if (start_s) begin
                    tower_r <= tower_coord;
                    idx_r   <= 2'd0;
                    found_r <= 1'b0;
`ifdef LASER_NEAREST_EN
                    best_sum_r <= 10'h3FF;
`endif
                end else if (state_r == SCAN) begin
                    idx_r   <= idx_r + 2'd1;
                    found_r <= found_next_s;
                    if (take_s) begin
                        sel_idx_r   <= idx_r;
                        sel_coord_r <= cur_coord_s;
`ifdef LASER_NEAREST_EN
                        best_sum_r  <= sum_s;
`endif
                    end
                end

                // The hit lands on the edge entering FIRE so outputs and health agree in that cycle.
                if (fire_go_s) begin
                    laser_fire_r      <= 1'b1;
                    laser_target_r    <= fire_idx_s;
                    laser_end_coord_r <= fire_coord_s;
                    if (health_r[fire_idx_s] != 4'd0)
                        health_r[fire_idx_s] <= health_r[fire_idx_s] - 4'd1;
                    if (health_r[fire_idx_s] == 4'd1)
                        destroyed_r[fire_idx_s] <= 1'b1;
                end
            end
        end
    end

    assign destroyed_cars  = destroyed_r;
    assign laser_fire      = laser_fire_r;
    assign laser_target    = laser_target_r;
    assign laser_end_coord = laser_end_coord_r;

endmodule

// File: tb/tb_laser_targeting.sv
// Scoreboard bench for laser_targeting: stimulus pushes expected fires, a monitor pops and compares.
module tb_laser_targeting;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stage_in_progress = 1'b0;
    logic        frame_tick = 1'b0;
    logic [14:0] tower_coord = 15'd0;
    logic [14:0] car_0_coords = 15'd0, car_1_coords = 15'd0, car_2_coords = 15'd0, car_3_coords = 15'd0;
    logic [3:0]  destroyed_cars;
    logic        laser_fire;
    logic [1:0]  laser_target;
    logic [14:0] laser_end_coord;

    laser_targeting dut (
        .clk(clk), .reset(reset), .stage_in_progress(stage_in_progress), .frame_tick(frame_tick),
        .tower_coord(tower_coord), .car_0_coords(car_0_coords), .car_1_coords(car_1_coords),
        .car_2_coords(car_2_coords), .car_3_coords(car_3_coords), .destroyed_cars(destroyed_cars),
        .laser_fire(laser_fire), .laser_target(laser_target), .laser_end_coord(laser_end_coord)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  tgt;
        logic [14:0] coord;
        logic [3:0]  dest;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int fires_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [14:0] xy(input int x, input int y);
        xy = {x[7:0], y[6:0]};
    endfunction

    // Monitor: every laser_fire pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (laser_fire === 1'b1) begin
            exp_t e;
            fires_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fire: fire at cycle %0d target %0d, required no fire", cyc, laser_target);
            end else begin
                e = exp_q.pop_front();
                check("fire_cycle", cyc, e.cyc);
                check("fire_target", 32'(laser_target), 32'(e.tgt));
                check("fire_coord", 32'(laser_end_coord), 32'(e.coord));
                check("fire_destroyed", 32'(destroyed_cars), 32'(e.dest));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(output int k);
        @(posedge clk); #1;
        frame_tick = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic quiet_frames(input int n);
        int k;
        repeat (n) begin
            tick(k);
            idle(18);
        end
    endtask

    task automatic fire_frame(input logic [1:0] tgt, input logic [14:0] coord, input logic [3:0] dest);
        int k;
        tick(k);
        exp_q.push_back('{32'(k + 5), tgt, coord, dest});
        idle(18);
    endtask

    task automatic rearm();
        @(posedge clk); #1;
        stage_in_progress = 1'b0;
        idle(5);
        stage_in_progress = 1'b1;
        idle(3);
    endtask

    task automatic scene(input logic [14:0] t, input logic [14:0] c0, input logic [14:0] c1,
                         input logic [14:0] c2, input logic [14:0] c3);
        tower_coord = t; car_0_coords = c0; car_1_coords = c1; car_2_coords = c2; car_3_coords = c3;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_destroyed"}, 32'(destroyed_cars), 32'd0);
        check({tag, "_fire"}, 32'(laser_fire), 32'd0);
        check({tag, "_target"}, 32'(laser_target), 32'd0);
        check({tag, "_coord"}, 32'(laser_end_coord), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int k;
        logic [3:0] dmask;
        // Reset: outputs zero, and no fire even with a live target while reset is held.
        idle(2);
        check_outputs_zero("reset");
        stage_in_progress = 1'b1;
        scene(xy(80, 60), xy(90, 60), 15'd0, 15'd0, 15'd0);
        quiet_frames(10);
        check_outputs_zero("reset_held");
        check("reset_no_fire", 32'(fires_seen), 32'd0);
        reset = 1'b0;
        idle(3);

        // Basic kill: fires every ninth frame (8 cooldown frames between), car 0 dies on the third hit.
        fire_frame(2'd0, xy(90, 60), 4'b0000);
        quiet_frames(8);
        fire_frame(2'd0, xy(90, 60), 4'b0000);
        quiet_frames(8);
        fire_frame(2'd0, xy(90, 60), 4'b0001);
        quiet_frames(10);
        check("kill_destroyed", 32'(destroyed_cars), 32'b0001);

        // Range boundaries.
        rearm();
        scene(xy(80, 60), 15'd0, xy(100, 40), 15'd0, 15'd0);
        fire_frame(2'd1, xy(100, 40), 4'b0000);
        rearm();
        scene(xy(80, 60), 15'd0, xy(101, 60), 15'd0, 15'd0);
        quiet_frames(2);
        rearm();
        scene(15'd0, 15'd0, 15'd0, 15'd0, 15'd0);
        quiet_frames(2);
        rearm();
        scene(xy(5, 3), 15'd0, xy(250, 3), 15'd0, 15'd0);
        quiet_frames(1);
        rearm();
        scene(xy(5, 3), 15'd0, xy(5, 124), 15'd0, 15'd0);
        quiet_frames(1);

        // Priority between two in-range cars, car 3 closer.
        rearm();
        scene(xy(80, 60), 15'd0, 15'd0, xy(100, 60), xy(82, 60));
`ifdef LASER_NEAREST_EN
        fire_frame(2'd3, xy(82, 60), 4'b0000);
`else
        fire_frame(2'd2, xy(100, 60), 4'b0000);
`endif

        // Reset raised mid-scan cancels the shot and clears outputs.
        rearm();
        scene(xy(80, 60), xy(90, 60), 15'd0, 15'd0, 15'd0);
        tick(k);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_outputs_zero("midscan_reset");
        idle(10);

        // A second frame_tick during SCAN must not restart the scan.
        tick(k);
        exp_q.push_back('{32'(k + 5), 2'd0, xy(90, 60), 4'b0000});
        idle(1);
        frame_tick = 1'b1;
        idle(1);
        frame_tick = 0;
        idle(20);

        // Destroy all four cars, then re-arm the stage.
        rearm();
        scene(xy(80, 60), xy(81, 60), xy(82, 60), xy(83, 60), xy(84, 60));
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                dmask = (j == 2) ? 4'((1 << (i + 1)) - 1) : 4'((1 << i) - 1);
                fire_frame(2'(i), xy(81 + i, 60), dmask);
                if (!(i == 3 && j == 2)) quiet_frames(8);
            end
        end
        quiet_frames(10);
        check("all_destroyed", 32'(destroyed_cars), 32'b1111);
        @(posedge clk); #1;
        stage_in_progress = 1'b0;
        tick(k);
        idle(3);
        check("stage_low_hold", 32'(destroyed_cars), 32'b1111);
        stage_in_progress = 1'b1;
        idle(1);
        check("stage_rearm_clear", 32'(destroyed_cars), 32'd0);
        idle(3);
        fire_frame(2'd0, xy(81, 60), 4'b0000);
        quiet_frames(8);
        fire_frame(2'd0, xy(81, 60), 4'b0000);
        quiet_frames(8);
        fire_frame(2'd0, xy(81, 60), 4'b0001);

        idle(20);
        check("pending_fires", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
